// File: rtl/toggle_req_responder.sv
// Receiving end of a two-phase toggle handshake: synchronises req_t, queues one event
// per toggle in a saturating counter, and acknowledges each consumed event on ack_t.
module toggle_req_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             req_t,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic             ack_t,
   output logic [CNT_W-1:0] pending,
   output logic             overflow
);

   typedef enum logic [1:0] {EMPTY, PART, FULL} occ_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist;
   logic                   det;
   logic                   cons;
   occ_e                   occ;
   logic [CNT_W-1:0]       pending_nxt;
   logic                   overflow_nxt;

   always_ff @(posedge clk) begin
      if (clear) begin
         sync_q <= '0;
         hist   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], req_t};
         hist   <= sync_q[SYNC_STAGES-1];
      end
   end

   assign det       = sync_q[SYNC_STAGES-1] ^ hist;
   assign evt_valid = (occ != EMPTY);
   assign cons      = evt_valid & evt_ready;

   // Occupancy is decoded purely from the registered counter, so evt_valid never
   // depends combinationally on evt_ready.
   always_comb begin
      occ = PART;
      if (pending == '0)
         occ = EMPTY;
      else if (pending == CNT_MAX)
         occ = FULL;
   end

   always_comb begin
      pending_nxt  = pending;
      overflow_nxt = overflow;
      case (occ)
         EMPTY: if (det) pending_nxt = pending + 1'b1;
         PART: begin
            if (det & ~cons)
               pending_nxt = pending + 1'b1;
            else if (~det & cons)
               pending_nxt = pending - 1'b1;
         end
         FULL: begin
            if (det & ~cons)
               overflow_nxt = 1'b1;
            else if (~det & cons)
               pending_nxt = pending - 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         pending  <= '0;
         overflow <= 1'b0;
         ack_t    <= 1'b0;
      end else begin
         pending  <= pending_nxt;
         overflow <= overflow_nxt;
         ack_t    <= ack_t ^ cons;
      end
   end

endmodule

// File: tb/tb_toggle_req_responder.sv
// Directed bench for toggle_req_responder: a narrow (CNT_W=2) and a wide (CNT_W=4)
// instance share stimulus; an event-queue model is checked every cycle.
module tb_toggle_req_responder;

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic       req_t = 1'b0;
   logic       evt_ready = 1'b0;
   logic       vld_n, ack_n, ovf_n;
   logic [1:0] pend_n;
   logic       vld_w, ack_w, ovf_w;
   logic [3:0] pend_w;

   int total = 0;
   int bad = 0;
   int edge_num = 0;
   int arr_q[$];
   bit armed = 0;
   int m_pend[2], m_ovf[2], m_ack[2], m_cons[2], m_drop[2];
   int cap[2] = '{3, 15};

   always #5 clk = ~clk;

   toggle_req_responder #(.SYNC_STAGES(2), .CNT_W(2)) u_n (
      .clk(clk), .clear(clear), .req_t(req_t), .evt_valid(vld_n), .evt_ready(evt_ready),
      .ack_t(ack_n), .pending(pend_n), .overflow(ovf_n));

   toggle_req_responder #(.SYNC_STAGES(2), .CNT_W(4)) u_w (
      .clk(clk), .clear(clear), .req_t(req_t), .evt_valid(vld_w), .evt_ready(evt_ready),
      .ack_t(ack_w), .pending(pend_w), .overflow(ovf_w));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Each toggle becomes an event seen on the third rising edge after it.
   task automatic toggle();
      req_t = ~req_t;
      arr_q.push_back(edge_num + 3);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      req_t = 1'b0;
      tick();
      clear = 1'b0;
   endtask

   // Model: a list of event arrival edges feeding a saturating occupancy count.
   initial forever begin : model
      bit det, cons;
      @(posedge clk);
      edge_num++;
      det = 1'b0;
      if (arr_q.size() > 0 && arr_q[0] == edge_num) begin
         det = 1'b1;
         void'(arr_q.pop_front());
      end
      if (clear) begin
         for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0; m_ovf[i] = 0; m_ack[i] = 0; m_cons[i] = 0; m_drop[i] = 0;
         end
         arr_q.delete();
         armed = 1;
      end else if (armed) begin
         for (int i = 0; i < 2; i++) begin
            cons = (m_pend[i] != 0) && evt_ready;
            if (cons) begin
               m_cons[i]++;
               m_ack[i] = 1 - m_ack[i];
            end
            if (det && !cons) begin
               if (m_pend[i] == cap[i]) begin
                  m_ovf[i] = 1;
                  m_drop[i]++;
               end else
                  m_pend[i]++;
            end else if (!det && cons)
               m_pend[i]--;
         end
      end
   end

   initial forever begin : compare
      @(negedge clk);
      if (armed) begin
         chk("n_pending", pend_n, m_pend[0]);
         chk("n_valid", vld_n, (m_pend[0] != 0));
         chk("n_ack", ack_n, m_ack[0]);
         chk("n_overflow", ovf_n, m_ovf[0]);
         chk("w_pending", pend_w, m_pend[1]);
         chk("w_valid", vld_w, (m_pend[1] != 0));
         chk("w_ack", ack_w, m_ack[1]);
         chk("w_overflow", ovf_w, m_ovf[1]);
      end
   end

   initial begin
      int sp;
      // 1: reset and quiet line
      repeat (3) tick();
      clear = 1'b0;
      chk("t1_pend", pend_n, 0);
      chk("t1_valid", vld_n, 0);
      chk("t1_ack", ack_n, 0);
      chk("t1_ovf", ovf_n, 0);
      repeat (10) tick();
      chk("t1_quiet_pend", pend_n, 0);
      chk("t1_quiet_valid", vld_n, 0);

      // 2: latency and single consume
      toggle();
      tick(); chk("t2_e1_pend", pend_n, 0);
      tick(); chk("t2_e2_pend", pend_n, 0); chk("t2_e2_valid", vld_n, 0);
      tick(); chk("t2_e3_pend", pend_n, 1); chk("t2_e3_valid", vld_n, 1);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      chk("t2_cons_pend", pend_n, 0);
      chk("t2_cons_ack", ack_n, 1);

      // 3: fill, overflow, drain
      do_clear();
      for (int k = 0; k < 3; k++) begin
         toggle();
         repeat (4) tick();
      end
      chk("t3_full_pend", pend_n, 3);
      chk("t3_full_ovf", ovf_n, 0);
      toggle();
      repeat (4) tick();
      chk("t3_drop_pend", pend_n, 3);
      chk("t3_drop_ovf", ovf_n, 1);
      chk("t3_wide_pend", pend_w, 4);
      chk("t3_wide_ovf", ovf_w, 0);
      evt_ready = 1'b1;
      repeat (3) tick();
      chk("t3_drain_pend", pend_n, 0);
      chk("t3_drain_ack", ack_n, 1);
      chk("t3_drain_ovf", ovf_n, 1);
      tick();
      chk("t3_wide_drain_pend", pend_w, 0);
      chk("t3_wide_drain_ack", ack_w, 0);
      evt_ready = 1'b0;

      // 4: detect and consume on the same edge
      do_clear();
      toggle();
      repeat (4) tick();
      chk("t4_pre_pend", pend_n, 1);
      toggle();
      tick();
      tick();
      evt_ready = 1'b1;
      tick();
      chk("t4_same_pend", pend_n, 1);
      chk("t4_same_ack", ack_n, 1);
      tick();
      chk("t4_next_pend", pend_n, 0);
      chk("t4_next_ack", ack_n, 0);
      evt_ready = 1'b0;

      // 5: clear mid-stream discards queued and in-flight events
      do_clear();
      toggle(); repeat (4) tick();
      toggle(); repeat (4) tick();
      chk("t5_pre_pend", pend_n, 2);
      toggle();
      tick();
      do_clear();
      chk("t5_clr_pend", pend_n, 0);
      chk("t5_clr_ack", ack_n, 0);
      chk("t5_clr_ovf", ovf_n, 0);
      repeat (6) tick();
      chk("t5_inflight_pend", pend_n, 0);
      chk("t5_inflight_wpend", pend_w, 0);

      // 6: wide capacity, then random consumer
      do_clear();
      for (int k = 0; k < 16; k++) begin
         toggle();
         sp = $urandom_range(6, 3);
         repeat (sp) tick();
      end
      chk("t6_wide_full", pend_w, 15);
      chk("t6_wide_ovf", ovf_w, 1);
      chk("t6_narrow_full", pend_n, 3);
      for (int k = 0; k < 4; k++) begin
         toggle();
         sp = $urandom_range(6, 3);
         for (int c = 0; c < sp; c++) begin
            evt_ready = 1'($urandom_range(1, 0));
            tick();
         end
      end
      evt_ready = 1'b1;
      repeat (20) tick();
      evt_ready = 1'b0;
      chk("t6_wide_drained", pend_w, 0);
      chk("t6_wide_events", m_cons[1] + m_drop[1], 20);
      chk("t6_narrow_events", m_cons[0] + m_drop[0], 20);
      chk("t6_wide_ack_parity", ack_w, m_cons[1] % 2);
      chk("t6_narrow_ack_parity", ack_n, m_cons[0] % 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
